operand_fetch_stage: RTL and testbench

//  Issue/operand-fetch pipeline stage directly upstream of the 16x16 register file.

---
 rtl/of_pkg.sv | 21 ++
 rtl/sb_counter_bank.sv | 82 ++++++++
 rtl/operand_fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// ---------------------------------------------------------------------------
// of_pkg
//   Shared types and constants for the operand-fetch stage and its pending-write
//   scoreboard. Register selects are 4 bits wide and data words are 16 bits,
//   matching the 16x16 register file the stage sits in front of.
// ---------------------------------------------------------------------------
package of_pkg;

  localparam int NREGS = 16;
  localparam int REGW  = 4;
  localparam int WORDW = 16;

  typedef logic [REGW-1:0]  regsel_t;
  typedef logic [WORDW-1:0] word_t;

  // True when an enabled port addresses the given register.
  function automatic logic sel_hit(input logic en, input regsel_t sel, input regsel_t r);
    return en && (sel == r);
  endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// ---------------------------------------------------------------------------
// sb_counter_bank
//   One pending-write counter per architectural register. An issued writer
//   increments its destination counter and a snooped writeback decrements it.
//   A simultaneous increment and decrement of the same register cancel out.
//   A writeback to a register with no outstanding writer leaves the count at
//   zero and sets a sticky error flag that only reset clears.
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   inc_en, inc_sel   increment strobe and target register
//   dec_en, dec_sel   decrement strobe and target register
//   pend              current count for every register
//   err               sticky underflow flag
// ---------------------------------------------------------------------------
module sb_counter_bank
  import of_pkg::*;
#(
  parameter int PENDW = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         inc_en,
  input  regsel_t                      inc_sel,
  input  logic                         dec_en,
  input  regsel_t                      dec_sel,
  output logic [NREGS-1:0][PENDW-1:0]  pend,
  output logic                         err
);

  localparam logic [PENDW-1:0] PEND_ZERO = {PENDW{1'b0}};
  localparam logic [PENDW-1:0] PEND_MAX  = {PENDW{1'b1}};
  localparam logic [PENDW-1:0] PEND_ONE  = PENDW'(1);

  logic [NREGS-1:0][PENDW-1:0] pend_r;
  logic [NREGS-1:0][PENDW-1:0] pend_nxt_s;
  logic                        err_r;
  logic                        err_hit_s;

  // Next-count computation for every register from the inc/dec strobes.
  always_comb begin
    pend_nxt_s = pend_r;
    err_hit_s  = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      case ({sel_hit(inc_en, inc_sel, regsel_t'(r)), sel_hit(dec_en, dec_sel, regsel_t'(r))})
        2'b10: begin
          // Issue logic never lets a counter reach this point at max; saturate anyway.
          if (pend_r[r] != PEND_MAX) begin
            pend_nxt_s[r] = pend_r[r] + PEND_ONE;
          end else begin
            pend_nxt_s[r] = pend_r[r];
          end
        end
        2'b01: begin
          if (pend_r[r] != PEND_ZERO) begin
            pend_nxt_s[r] = pend_r[r] - PEND_ONE;
          end else begin
            pend_nxt_s[r] = pend_r[r];
            err_hit_s     = 1'b1;
          end
        end
        default: begin
          pend_nxt_s[r] = pend_r[r];
        end
      endcase
    end
  end

  // Counter state and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_r <= '0;
      err_r  <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      err_r  <= err_r | err_hit_s;
    end
  end

  assign pend = pend_r;
  assign err  = err_r;

endmodule

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//   Issue / operand-fetch stage in front of the 16x16 register file. Read
//   selects go straight to the register file; returned data (or same-cycle
//   writeback data when that writeback retires the last outstanding writer)
//   is captured into a one-deep registered output stage. A pending-write
//   scoreboard blocks issue on read-after-write and on a destination whose
//   counter is already full.
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake
//   in_rs1/in_rs2/in_rd/in_rd_wen instruction register fields
//   in_tag                        opaque tag carried to the output
//   rsel1/rsel2, rdat1/rdat2      register file read port
//   wb_wen/wb_sel/wb_dat          snoop of the register file write port
//   out_valid/out_ready           downstream handshake
//   out_op1/out_op2/out_rd/out_rd_wen/out_tag  registered operands and fields
//   sb_err                        sticky: writeback with no outstanding writer
// ---------------------------------------------------------------------------
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int TAGW  = 8,
  parameter int PENDW = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  regsel_t         in_rs1,
  input  regsel_t         in_rs2,
  input  regsel_t         in_rd,
  input  logic            in_rd_wen,
  input  logic [TAGW-1:0] in_tag,
  output regsel_t         rsel1,
  output regsel_t         rsel2,
  input  word_t           rdat1,
  input  word_t           rdat2,
  input  logic            wb_wen,
  input  regsel_t         wb_sel,
  input  word_t           wb_dat,
  output logic            out_valid,
  input  logic            out_ready,
  output word_t           out_op1,
  output word_t           out_op2,
  output regsel_t         out_rd,
  output logic            out_rd_wen,
  output logic [TAGW-1:0] out_tag,
  output logic            sb_err
);

  localparam logic [PENDW-1:0] PEND_ZERO = {PENDW{1'b0}};
  localparam logic [PENDW-1:0] PEND_MAX  = {PENDW{1'b1}};
  localparam logic [PENDW-1:0] PEND_ONE  = PENDW'(1);

  logic [NREGS-1:0][PENDW-1:0] pend_s;
  logic [PENDW-1:0]            pend_rs1_s;
  logic [PENDW-1:0]            pend_rs2_s;
  logic [PENDW-1:0]            pend_rd_s;
  logic                        fwd1_s;
  logic                        fwd2_s;
  logic                        raw1_s;
  logic                        raw2_s;
  logic                        waw_s;
  logic                        hazard_s;
  logic                        in_ready_s;
  logic                        accept_s;
  logic                        err_s;
  word_t                       op1_s;
  word_t                       op2_s;

  logic                        out_valid_r;
  word_t                       out_op1_r;
  word_t                       out_op2_r;
  regsel_t                     out_rd_r;
  logic                        out_rd_wen_r;
  logic [TAGW-1:0]             out_tag_r;

  assign rsel1 = in_rs1;
  assign rsel2 = in_rs2;

  assign pend_rs1_s = pend_s[in_rs1];
  assign pend_rs2_s = pend_s[in_rs2];
  assign pend_rd_s  = pend_s[in_rd];

  // Hazard, forwarding and handshake decisions. All scoreboard reads use the
  // current count, so an instruction that reads its own destination sees the
  // value before its own increment.
  always_comb begin
    // Forward only when this writeback retires the last outstanding writer;
    // an older writeback would hand over stale data.
    fwd1_s = sel_hit(wb_wen, wb_sel, in_rs1) && (pend_rs1_s == PEND_ONE);
    fwd2_s = sel_hit(wb_wen, wb_sel, in_rs2) && (pend_rs2_s == PEND_ONE);

    raw1_s = (pend_rs1_s != PEND_ZERO) && !fwd1_s;
    raw2_s = (pend_rs2_s != PEND_ZERO) && !fwd2_s;

    // A full counter may still accept a new writer when a writeback to the
    // same register frees a slot in the same cycle.
    waw_s = in_rd_wen && (pend_rd_s == PEND_MAX) && !sel_hit(wb_wen, wb_sel, in_rd);

    hazard_s   = raw1_s | raw2_s | waw_s;
    in_ready_s = (!out_valid_r || out_ready) && !hazard_s;
    accept_s   = in_valid && in_ready_s;

    if (fwd1_s) begin
      op1_s = wb_dat;
    end else begin
      op1_s = rdat1;
    end

    if (fwd2_s) begin
      op2_s = wb_dat;
    end else begin
      op2_s = rdat2;
    end
  end

  sb_counter_bank #(
    .PENDW (PENDW)
  ) u_sb (
    .CLK     (CLK),
    .RST     (RST),
    .inc_en  (accept_s && in_rd_wen),
    .inc_sel (in_rd),
    .dec_en  (wb_wen),
    .dec_sel (wb_sel),
    .pend    (pend_s),
    .err     (err_s)
  );

  // Output pipeline register: load on accept, drain on downstream ready,
  // otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_r  <= 1'b0;
      out_op1_r    <= '0;
      out_op2_r    <= '0;
      out_rd_r     <= '0;
      out_rd_wen_r <= 1'b0;
      out_tag_r    <= '0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_op1_r    <= op1_s;
      out_op2_r    <= op2_s;
      out_rd_r     <= in_rd;
      out_rd_wen_r <= in_rd_wen;
      out_tag_r    <= in_tag;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_op1    = out_op1_r;
  assign out_op2    = out_op2_r;
  assign out_rd     = out_rd_r;
  assign out_rd_wen = out_rd_wen_r;
  assign out_tag    = out_tag_r;
  assign sb_err     = err_s;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  import of_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  regsel_t     in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [7:0]  in_tag;
  regsel_t     rsel1, rsel2;
  word_t       rdat1, rdat2;
  logic        wb_wen;
  regsel_t     wb_sel;
  word_t       wb_dat;
  logic        out_valid;
  logic        out_ready;
  word_t       out_op1, out_op2;
  regsel_t     out_rd;
  logic        out_rd_wen;
  logic [7:0]  out_tag;
  logic        sb_err;

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  rd;
    logic        wen;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  operand_fetch_stage #(.TAGW(8), .PENDW(2)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_tag(in_tag),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .wb_wen(wb_wen), .wb_sel(wb_sel), .wb_dat(wb_dat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .out_tag(out_tag), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: a transfer completes at the next rising edge whenever
  // valid and ready are both high at the falling edge.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      exp_t got;
      exp_t exp;
      got = {out_op1, out_op2, out_rd, out_rd_wen, out_tag};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected got=%h expected=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL scoreboard got op1=%h op2=%h rd=%0d wen=%0b tag=%h expected op1=%h op2=%h rd=%0d wen=%0b tag=%h",
                   got.op1, got.op2, got.rd, got.wen, got.tag,
                   exp.op1, exp.op2, exp.rd, exp.wen, exp.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_in(input logic v, input regsel_t rs1, input regsel_t rs2,
                          input regsel_t rd, input logic wen, input logic [7:0] tag,
                          input word_t d1, input word_t d2);
    in_valid  = v;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_rd_wen = wen;
    in_tag    = tag;
    rdat1     = d1;
    rdat2     = d2;
  endtask

  task automatic drive_wb(input logic en, input regsel_t sel, input word_t dat);
    wb_wen = en;
    wb_sel = sel;
    wb_dat = dat;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive_in(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 16'h0000, 16'h0000);
    drive_wb(1'b0, 4'd0, 16'h0000);
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || out_op1 !== 16'h0000 || out_op2 !== 16'h0000 ||
        out_rd !== 4'd0 || out_rd_wen !== 1'b0 || out_tag !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got v=%b op1=%h op2=%h rd=%0d wen=%b tag=%h expected all zero",
               out_valid, out_op1, out_op2, out_rd, out_rd_wen, out_tag);
    end
    checks++;
    if (sb_err !== 1'b0 || dut.pend_s !== '0) begin
      errors++;
      $display("FAIL reset_scoreboard got sb_err=%b pend=%h expected 0 and 0", sb_err, dut.pend_s);
    end
    tick();
    RST = 1'b0;
  endtask

  task automatic test_basic();
    drive_in(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 8'h11, 16'h1111, 16'h2222);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1 || rsel1 !== 4'd1 || rsel2 !== 4'd2) begin
      errors++;
      $display("FAIL basic_ready got ready=%b rsel1=%0d rsel2=%0d expected 1 1 2", in_ready, rsel1, rsel2);
    end
    exp_q.push_back({16'h1111, 16'h2222, 4'd3, 1'b1, 8'h11});
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (dut.pend_s[3] !== 2'd1) begin
      errors++;
      $display("FAIL basic_pend3 got %0d expected 1", dut.pend_s[3]);
    end
    tick();
    drive_wb(1'b1, 4'd3, 16'h3333);
    tick();
    drive_wb(1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (dut.pend_s[3] !== 2'd0 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_retire got pend3=%0d sb_err=%b expected 0 0", dut.pend_s[3], sb_err);
    end
    tick();
  endtask

  task automatic test_raw_forward();
    drive_in(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 8'h21, 16'h0A0A, 16'h0B0B);
    @(negedge CLK);
    exp_q.push_back({16'h0A0A, 16'h0B0B, 4'd5, 1'b1, 8'h21});
    tick();
    drive_in(1'b1, 4'd5, 4'd6, 4'd0, 1'b0, 8'h22, 16'h5555, 16'h6666);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall cycle %0d got ready=%b expected 0", i, in_ready);
      end
      tick();
    end
    drive_wb(1'b1, 4'd5, 16'hBEEF);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_fwd_ready got %b expected 1", in_ready);
    end
    exp_q.push_back({16'hBEEF, 16'h6666, 4'd0, 1'b0, 8'h22});
    tick();
    in_valid = 1'b0;
    drive_wb(1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (dut.pend_s[5] !== 2'd0) begin
      errors++;
      $display("FAIL raw_pend5 got %0d expected 0", dut.pend_s[5]);
    end
    tick();
  endtask

  task automatic test_double_writer();
    drive_in(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 8'h31, 16'h0101, 16'h0202);
    exp_q.push_back({16'h0101, 16'h0202, 4'd7, 1'b1, 8'h31});
    tick();
    drive_in(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 8'h32, 16'h0303, 16'h0404);
    exp_q.push_back({16'h0303, 16'h0404, 4'd7, 1'b1, 8'h32});
    tick();
    // Reader uses r7 on both sources.
    drive_in(1'b1, 4'd7, 4'd7, 4'd8, 1'b0, 8'h33, 16'h7777, 16'h7777);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || dut.pend_s[7] !== 2'd2) begin
      errors++;
      $display("FAIL dw_stall got ready=%b pend7=%0d expected 0 2", in_ready, dut.pend_s[7]);
    end
    tick();
    drive_wb(1'b1, 4'd7, 16'h0001);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL dw_first_wb got ready=%b expected 0", in_ready);
    end
    tick();
    drive_wb(1'b1, 4'd7, 16'h0002);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dw_second_wb got ready=%b expected 1", in_ready);
    end
    exp_q.push_back({16'h0002, 16'h0002, 4'd8, 1'b0, 8'h33});
    tick();
    in_valid = 1'b0;
    drive_wb(1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (dut.pend_s[7] !== 2'd0) begin
      errors++;
      $display("FAIL dw_pend7 got %0d expected 0", dut.pend_s[7]);
    end
    tick();
  endtask

  task automatic test_waw();
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 8'h40 + 8'(i), 16'h4000 + 16'(i), 16'h4100 + 16'(i));
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL waw_fill %0d got ready=%b expected 1", i, in_ready);
      end
      exp_q.push_back({16'h4000 + 16'(i), 16'h4100 + 16'(i), 4'd4, 1'b1, 8'h40 + 8'(i)});
      tick();
    end
    drive_in(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 8'h43, 16'h4444, 16'h4545);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b0 || dut.pend_s[4] !== 2'd3) begin
        errors++;
        $display("FAIL waw_stall %0d got ready=%b pend4=%0d expected 0 3", i, in_ready, dut.pend_s[4]);
      end
      tick();
    end
    drive_wb(1'b1, 4'd4, 16'hAAAA);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_release got ready=%b expected 1", in_ready);
    end
    exp_q.push_back({16'h4444, 16'h4545, 4'd4, 1'b1, 8'h43});
    tick();
    in_valid = 1'b0;
    drive_wb(1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (dut.pend_s[4] !== 2'd3) begin
      errors++;
      $display("FAIL waw_pend_hold got %0d expected 3", dut.pend_s[4]);
    end
    tick();
    drive_wb(1'b1, 4'd4, 16'hBBBB);
    repeat (3) tick();
    drive_wb(1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (dut.pend_s[4] !== 2'd0 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL waw_drain got pend4=%0d sb_err=%b expected 0 0", dut.pend_s[4], sb_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_in(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 8'h51, 16'hA1A1, 16'hA2A2);
    @(negedge CLK);
    exp_q.push_back({16'hA1A1, 16'hA2A2, 4'd0, 1'b0, 8'h51});
    tick();
    drive_in(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 8'h52, 16'hB1B1, 16'hB2B2);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op1 !== 16'hA1A1 ||
          out_op2 !== 16'hA2A2 || out_tag !== 8'h51) begin
        errors++;
        $display("FAIL bp_hold %0d got ready=%b v=%b op1=%h op2=%h tag=%h expected 0 1 a1a1 a2a2 51",
                 i, in_ready, out_valid, out_op1, out_op2, out_tag);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ready=%b expected 1", in_ready);
    end
    exp_q.push_back({16'hB1B1, 16'hB2B2, 4'd0, 1'b0, 8'h52});
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained got out_valid=%b expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_sb_err();
    @(negedge CLK);
    checks++;
    if (sb_err !== 1'b0) begin
      errors++;
      $display("FAIL err_before got %b expected 0", sb_err);
    end
    tick();
    drive_wb(1'b1, 4'd9, 16'h1234);
    tick();
    drive_wb(1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (sb_err !== 1'b1 || dut.pend_s[9] !== 2'd0) begin
        errors++;
        $display("FAIL err_sticky %0d got sb_err=%b pend9=%0d expected 1 0", i, sb_err, dut.pend_s[9]);
      end
      tick();
    end
    // Reset with an instruction parked in the output register.
    out_ready = 1'b0;
    drive_in(1'b1, 4'd0, 4'd0, 4'd10, 1'b1, 8'h61, 16'h6161, 16'h6262);
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || dut.pend_s[10] !== 2'd1) begin
      errors++;
      $display("FAIL mid_before got v=%b pend10=%0d expected 1 1", out_valid, dut.pend_s[10]);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || out_tag !== 8'h00 || dut.pend_s[10] !== 2'd0 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b tag=%h pend10=%0d sb_err=%b expected 0 00 0 0",
               out_valid, out_tag, dut.pend_s[10], sb_err);
    end
    tick();
    drive_wb(1'b1, 4'd10, 16'h0A0A);
    tick();
    drive_wb(1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (sb_err !== 1'b1 || dut.pend_s[10] !== 2'd0) begin
      errors++;
      $display("FAIL err_after_reset got sb_err=%b pend10=%0d expected 1 0", sb_err, dut.pend_s[10]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_forward();
    test_double_writer();
    test_waw();
    test_back_to_back();
    test_sb_err();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
